// File: rtl/uart_rx_if.sv
// Serial line plus receive-side results of the 8N1 UART receiver.
// master: the receiver itself; slave: whoever drives the line and consumes bytes.
interface uart_rx_if;
  logic       rxd;
  logic [7:0] rdata;
  logic       rx_ready;
  logic       ferr;
  logic       rx_busy;

  modport master (input rxd, output rdata, rx_ready, ferr, rx_busy);
  modport slave  (output rxd, input rdata, rx_ready, ferr, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with centre-of-bit sampling, timed by a free-running frame cycle counter.
// state | meaning: s_idle wait edge | s_start_bit confirm start | s_bit_0..7 data | s_stop_bit stop
module uart_rx #(
  parameter int unsigned CLK_PER_HALF_BIT = 434
) (
  input  logic      clk,
  input  logic      rstn,
  uart_rx_if.master rx_if
);

  typedef enum logic [3:0] {
    s_idle      = 4'd0,
    s_start_bit = 4'd1,
    s_bit_0     = 4'd2,
    s_bit_1     = 4'd3,
    s_bit_2     = 4'd4,
    s_bit_3     = 4'd5,
    s_bit_4     = 4'd6,
    s_bit_5     = 4'd7,
    s_bit_6     = 4'd8,
    s_bit_7     = 4'd9,
    s_stop_bit  = 4'd10
  } state_t;

  localparam logic [31:0] HALF = 32'(CLK_PER_HALF_BIT);
  localparam logic [31:0] FULL = HALF + HALF;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        rxd_s_q, rxd_s_d;
  logic        rxd_p_q, rxd_p_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tgt_q, tgt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rx_ready_q, rx_ready_d;
  logic        ferr_q, ferr_d;
  logic        rx_busy_q, rx_busy_d;

  logic fall;
  logic strobe;

  assign fall   = rxd_p_q & ~rxd_s_q;
  assign strobe = (cnt_q == tgt_q);

  always_comb begin
    sync1_d    = rx_if.rxd;
    rxd_s_d    = sync1_q;
    rxd_p_d    = rxd_s_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    shift_d    = shift_q;
    rdata_d    = rdata_q;
    rx_ready_d = 1'b0;
    ferr_d     = 1'b0;
    rx_busy_d  = rx_busy_q;

    if (state_q == s_idle) begin
      if (fall) begin
        state_d   = s_start_bit;
        cnt_d     = 32'd0;
        tgt_d     = HALF - 32'd1;
        rx_busy_d = 1'b1;
      end
    end else begin
      // cnt_q equals (cycles since start edge) - 1; strobes land on odd multiples of HALF
      cnt_d = cnt_q + 32'd1;
      if (strobe) begin
        tgt_d = tgt_q + FULL;
        case (state_q)
          s_start_bit: begin
            if (rxd_s_q) begin
              state_d   = s_idle;
              rx_busy_d = 1'b0;
            end else begin
              state_d = s_bit_0;
            end
          end
          s_bit_0, s_bit_1, s_bit_2, s_bit_3,
          s_bit_4, s_bit_5, s_bit_6, s_bit_7: begin
            shift_d = {rxd_s_q, shift_q[7:1]};
            state_d = state_t'(state_q + 4'd1);
          end
          s_stop_bit: begin
            state_d    = s_idle;
            rdata_d    = shift_q;
            rx_busy_d  = 1'b0;
            rx_ready_d = rxd_s_q;
            ferr_d     = ~rxd_s_q;
          end
          default: begin
            state_d   = s_idle;
            rx_busy_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= s_idle;
      sync1_q    <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_p_q    <= 1'b1;
      cnt_q      <= 32'd0;
      tgt_q      <= 32'd0;
      shift_q    <= 8'd0;
      rdata_q    <= 8'd0;
      rx_ready_q <= 1'b0;
      ferr_q     <= 1'b0;
      rx_busy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rxd_s_q    <= rxd_s_d;
      rxd_p_q    <= rxd_p_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      shift_q    <= shift_d;
      rdata_q    <= rdata_d;
      rx_ready_q <= rx_ready_d;
      ferr_q     <= ferr_d;
      rx_busy_q  <= rx_busy_d;
    end
  end

  assign rx_if.rdata    = rdata_q;
  assign rx_if.rx_ready = rx_ready_q;
  assign rx_if.ferr     = ferr_q;
  assign rx_if.rx_busy  = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at the default bit period and one with a 4-clock half bit.
module tb_uart_rx;
  localparam int H_BIG = 434;
  localparam int H_SM  = 4;

  logic clk = 1'b0;
  logic rstn_b;
  logic rstn_s;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  uart_rx_if ifb ();
  uart_rx_if ifs ();

  uart_rx #(.CLK_PER_HALF_BIT(H_BIG)) dut_b (.clk(clk), .rstn(rstn_b), .rx_if(ifb));
  uart_rx #(.CLK_PER_HALF_BIT(H_SM))  dut_s (.clk(clk), .rstn(rstn_s), .rx_if(ifs));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int         rdy_b = 0, ferr_b = 0, both_b = 0, rdy_cyc_b = 0;
  int         rdy_s = 0, ferr_s = 0, both_s = 0, busy_s = 0, rdy_cyc_s = 0, ferr_cyc_s = 0;
  logic [7:0] dat_s [0:15];

  // Pulse monitor, sampled mid-cycle so registered outputs are stable
  always @(negedge clk) begin
    if (ifb.rx_ready === 1'b1) begin
      rdy_b     <= rdy_b + 1;
      rdy_cyc_b <= cyc;
    end
    if (ifb.ferr === 1'b1) ferr_b <= ferr_b + 1;
    if (ifb.rx_ready === 1'b1 && ifb.ferr === 1'b1) both_b <= both_b + 1;
    if (ifs.rx_ready === 1'b1) begin
      rdy_s             <= rdy_s + 1;
      rdy_cyc_s         <= cyc;
      dat_s[rdy_s & 15] <= ifs.rdata;
    end
    if (ifs.ferr === 1'b1) begin
      ferr_s     <= ferr_s + 1;
      ferr_cyc_s <= cyc;
    end
    if (ifs.rx_ready === 1'b1 && ifs.ferr === 1'b1) both_s <= both_s + 1;
    if (ifs.rx_busy === 1'b1) busy_s <= busy_s + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first, then a stop bit of stop_len cycles; line then set to after_v
  task automatic send(input bit big, input logic [7:0] d, input logic stop_v,
                      input int stop_len, input logic after_v);
    int         bl;
    logic [9:0] fr;
    bl = big ? 2 * H_BIG : 2 * H_SM;
    fr = {stop_v, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (big) ifb.rxd = fr[i];
      else     ifs.rxd = fr[i];
      repeat ((i == 9) ? stop_len : bl) tick();
    end
    if (big) ifb.rxd = after_v;
    else     ifs.rxd = after_v;
  endtask

  initial begin
    int c0, r0, f0, b0;
    rstn_b  = 1'b0;
    rstn_s  = 1'b0;
    ifb.rxd = 1'b1;
    ifs.rxd = 1'b1;
    repeat (3) tick();

    check("rst_rdata_s",  32'(ifs.rdata),    32'h0);
    check("rst_ready_s",  32'(ifs.rx_ready), 32'h0);
    check("rst_ferr_s",   32'(ifs.ferr),     32'h0);
    check("rst_busy_s",   32'(ifs.rx_busy),  32'h0);
    check("rst_rdata_b",  32'(ifb.rdata),    32'h0);
    check("rst_busy_b",   32'(ifb.rx_busy),  32'h0);

    rstn_b = 1'b1;
    rstn_s = 1'b1;
    repeat (3) tick();

    // Default period, frame 0x55
    c0 = cyc;
    send(1'b1, 8'h55, 1'b1, 2 * H_BIG, 1'b1);
    repeat (20) tick();
    check("big_ready_count", 32'(rdy_b), 32'd1);
    check("big_latency",     32'(rdy_cyc_b - c0), 32'(19 * H_BIG + 3));
    check("big_rdata",       32'(ifb.rdata), 32'h55);
    check("big_ferr_count",  32'(ferr_b), 32'd0);

    // 3-cycle glitch is a false start
    r0 = rdy_s; f0 = ferr_s; b0 = busy_s;
    ifs.rxd = 1'b0;
    repeat (3) tick();
    ifs.rxd = 1'b1;
    repeat (20) tick();
    check("glitch_ready", 32'(rdy_s - r0), 32'd0);
    check("glitch_ferr",  32'(ferr_s - f0), 32'd0);
    check("glitch_busy_cycles", 32'(busy_s - b0), 32'(H_SM));

    r0 = rdy_s; c0 = cyc;
    send(1'b0, 8'hA5, 1'b1, 8, 1'b1);
    repeat (10) tick();
    check("a5_ready_count", 32'(rdy_s - r0), 32'd1);
    check("a5_latency",     32'(rdy_cyc_s - c0), 32'(19 * H_SM + 3));
    check("a5_rdata",       32'(ifs.rdata), 32'hA5);

    // Framing error followed by a held break
    r0 = rdy_s; f0 = ferr_s; c0 = cyc;
    send(1'b0, 8'h3C, 1'b0, 8, 1'b0);
    check("brk_ferr_time", 32'(ferr_cyc_s - c0), 32'(19 * H_SM + 3));
    repeat (40) tick();
    ifs.rxd = 1'b1;
    repeat (30) tick();
    check("brk_ferr_count",  32'(ferr_s - f0), 32'd1);
    check("brk_ready_count", 32'(rdy_s - r0), 32'd0);
    check("brk_rdata",       32'(ifs.rdata), 32'h3C);
    check("brk_busy_idle",   32'(ifs.rx_busy), 32'h0);

    // Back-to-back with a short (7-cycle) stop bit
    r0 = rdy_s; c0 = cyc;
    send(1'b0, 8'hA5, 1'b1, 7, 1'b1);
    send(1'b0, 8'h0F, 1'b1, 8, 1'b1);
    repeat (10) tick();
    check("b2b_ready_count", 32'(rdy_s - r0), 32'd2);
    check("b2b_first",       32'(dat_s[r0 & 15]), 32'hA5);
    check("b2b_second",      32'(dat_s[(r0 + 1) & 15]), 32'h0F);
    check("b2b_second_time", 32'(rdy_cyc_s - c0), 32'(2 * (19 * H_SM + 3)));

    // Reset pulse during bit 3 of 0xFF
    r0 = rdy_s; f0 = ferr_s;
    fork
      send(1'b0, 8'hFF, 1'b1, 8, 1'b1);
      begin
        repeat (34) tick();
        check("ff_busy_before_rst", 32'(ifs.rx_busy), 32'h1);
        rstn_s = 1'b0;
        tick();
        check("midrst_rdata", 32'(ifs.rdata),    32'h0);
        check("midrst_busy",  32'(ifs.rx_busy),  32'h0);
        check("midrst_ready", 32'(ifs.rx_ready), 32'h0);
        check("midrst_ferr",  32'(ifs.ferr),     32'h0);
        rstn_s = 1'b1;
      end
    join
    repeat (10) tick();
    check("ff_ready_count", 32'(rdy_s - r0), 32'd0);
    check("ff_ferr_count",  32'(ferr_s - f0), 32'd0);

    r0 = rdy_s;
    send(1'b0, 8'h81, 1'b1, 8, 1'b1);
    repeat (10) tick();
    check("x81_ready_count", 32'(rdy_s - r0), 32'd1);
    check("x81_rdata",       32'(ifs.rdata), 32'h81);

    check("overlap_small", 32'(both_s), 32'd0);
    check("overlap_big",   32'(both_b), 32'd0);
    check("big_no_extra",  32'(rdy_b), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
